// File: rtl/booth_r4_seq_mul_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // One radix-4 Booth digit: magnitude one or two, optionally negated.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_dig_t;

  function automatic int mul_ndig(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_seq_mul_if.sv
// Operand-issue and result handshakes of the sequential Booth multiplier.
interface booth_r4_seq_mul_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_signed;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;
  logic                 busy;

  modport master (
    output in_valid, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_product, busy
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_product, busy
  );
endinterface

// File: rtl/booth_r4_seq_mul_enc.sv
// Radix-4 Booth recoder: {b[2i+1], b[2i], b[2i-1]} -> digit in {-2..+2}.
module booth_r4_enc
  import mul_pkg::*;
(
  input  logic [2:0]  win_i,
  output booth_dig_t  dig_o
);

  // 111 and 000 both encode zero, so neg is suppressed for 111.
  assign dig_o.neg = win_i[2] & ~(win_i[1] & win_i[0]);
  assign dig_o.one = win_i[1] ^ win_i[0];
  assign dig_o.two = (win_i == 3'b011) | (win_i == 3'b100);

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Sequential radix-4 Booth multiplier: one digit per clock, valid/ready on both sides.
module booth_r4_seq_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  booth_r4_seq_mul_if.slave  bus
);

  localparam int NDIG = mul_ndig(WIDTH);
  localparam int EW   = WIDTH + 2;
  localparam int AW   = 2 * WIDTH + 2;
  localparam int CW   = $clog2(NDIG);

  localparam logic [1:0]    S_IDLE   = IDLE;
  localparam logic [1:0]    S_CALC   = CALC;
  localparam logic [1:0]    S_DONE   = DONE;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_r4_seq_mul: WIDTH must be even and at least 4");
  end

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [EW-1:0]      a_q, a_d;
  logic [EW:0]        b_q, b_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic               ext_sign_a, ext_sign_b;
  booth_dig_t         dig;
  logic [AW-1:0]      a_sx, pp_mag, pp, pp_sh;

  assign ext_sign_a = bus.in_signed & bus.in_a[WIDTH-1];
  assign ext_sign_b = bus.in_signed & bus.in_b[WIDTH-1];

  // b_q carries the implicit b[-1]=0 in bit 0 and shifts down two bits per
  // digit, so the current Booth window is always b_q[2:0].
  booth_r4_enc u_enc (
    .win_i (b_q[2:0]),
    .dig_o (dig)
  );

  assign a_sx   = {{(AW - EW){a_q[EW-1]}}, a_q};
  assign pp_mag = dig.two ? (a_sx << 1) : (dig.one ? a_sx : '0);
  assign pp     = dig.neg ? (~pp_mag + 1'b1) : pp_mag;
  assign pp_sh  = pp << {cnt_q, 1'b0};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = {{2{ext_sign_a}}, bus.in_a};
          b_d     = {{2{ext_sign_b}}, bus.in_b, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = acc_q + pp_sh;
        b_d   = b_q >> 2;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_DIG) begin
          cnt_d   = '0;
          prod_d  = acc_d[2*WIDTH-1:0];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.out_product = prod_q;

endmodule
